circle_plotter: RTL
===================

// Module: circle_plotter
// PURPOSE
//  Midpoint (Bresenham) circle engine driving the pixel-write side of vga_adapter.
//  The task3 top instantiates it between board I/O and the 160x120 adapter.
//  On start it emits one candidate pixel per clock on vga_x/vga_y/vga_plot.
//  It raises done when the full outline is drawn.
// PARAMETERS
//  SCREEN_W  160  visible columns; x outside 0..SCREEN_W-1 is clipped
//  SCREEN_H  120  visible rows; y outside 0..SCREEN_H-1 is clipped
// PORTS
//  clk         in   1  system clock (CLOCK_50 at top)
//  rst_n       in   1  reset, asynchronous, active-low
//  start       in   1  request; held high by requester until done seen
//  colour      in   3  outline colour, latched when start accepted
//  centre_x    in   8  centre column, latched when start accepted
//  centre_y    in   7  centre row, latched when start accepted
//  radius      in   8  radius 0..255, latched when start accepted
//  done        out  1  drawing complete
//  vga_x       out  8  pixel column to adapter
//  vga_y       out  7  pixel row to adapter
//  vga_colour  out  3  pixel colour to adapter
//  vga_plot    out  1  write strobe; adapter samples on the next rising clk
// BEHAVIOUR
//  - Reset (async, rst_n=0) forces IDLE; done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
//    Reset mid-draw abandons the circle at once; no further plots.
//  - FSM: IDLE -> INIT -> PLOT (oct 0..7) -> STEP -> {PLOT | DONE}; DONE -> IDLE.
//  - IDLE: start=1 on an edge latches inputs and moves to INIT.
//  - INIT: off_x=radius, off_y=0, crit=1-radius, oct=0.
//  - PLOT: one octant per cycle; oct increments; after oct 7 go to STEP.
//    Octant points, in order:
//    0 (cx+ox,cy+oy)  1 (cx+oy,cy+ox)  2 (cx-ox,cy+oy)  3 (cx-oy,cy+ox)
//    4 (cx-ox,cy-oy)  5 (cx-oy,cy-ox)  6 (cx+ox,cy-oy)  7 (cx+oy,cy-ox)
//  - Outputs during PLOT are combinational from the current registers:
//    vga_x/vga_y take the point's low bits; vga_colour is the latched colour.
//    vga_plot=1 only if 0<=px<SCREEN_W and 0<=py<SCREEN_H.
//    A clipped point still costs its cycle, so timing is independent of clipping.
//  - STEP: off_y+=1.
//    If crit<=0: crit+=2*off_y_new+1.
//    Else: off_x-=1 and crit+=2*(off_y_new-off_x_new)+1.
//    Then go to DONE if off_y_new>off_x_new, otherwise PLOT with oct=0.
//  - Widths: off_x/off_y 9b unsigned; crit 11b signed; point arithmetic 10b signed.
//    No overflow is possible for any 8b radius.
//  - Latency: N midpoint iterations take exactly 1+9N clocks from the start-sampling edge to done=1.
//  - Outside PLOT: vga_plot=0 and vga_x/vga_y/vga_colour=0.
//  - DONE: done=1 while start=1.
//    When start=0 is sampled: go to IDLE, done=0 on the next cycle.
//  - Handshake edges: start dropped mid-draw is ignored; the circle completes,
//    done pulses for one cycle, then IDLE. Start high in IDLE re-triggers a new circle.
//    Input changes after acceptance have no effect.
//  - radius=0: one iteration, all 8 points equal the centre.
// STRUCTURE
//  - circle_pkg holds:
//    state_t enum {IDLE,INIT,PLOT,STEP,DONE}
//    SCREEN_W_DEF/SCREEN_H_DEF
//    COORD_W=10 (signed point width), CRIT_W=11
//  - Sub-module octant_point (combinational):
//    (cx,cy,ox,oy,oct) -> signed (px,py) plus in_bounds flag.
//  - Everything else (FSM, offset/crit registers, input latches) stays in circle_plotter.
// TESTING
//  1 Reset with rst_n=0 mid-draw, then rst_n=1 -> outputs 0, state IDLE, no vga_plot until next start.
//  2 Centre (80,60), r=0 -> 8 plots at (80,60); done=1 exactly 10 clocks after start sampled.
//  3 Centre (80,60), r=40 -> first 8 points (120,60)(80,100)(40,60)(80,100)(40,60)(80,20)(120,60)(80,20);
//    all plotted pixels satisfy |dist-40|<1; done after 1+9N clocks.
//  4 Centre (0,0), r=10 -> vga_plot=0 on every point with negative x or y; cycle count matches the unclipped case.
//  5 Centre (80,60), r=1, colour=3'b101 -> 16 point cycles; done at clock 19.
//    Changing colour/radius mid-draw does not alter the output; vga_colour stays 3'b101.
//  6 Start held after done -> done stays 1; drop start -> done=0 next cycle.
//    Raise start again -> a new circle is accepted.

Source files
------------

// File: rtl/circle_plotter_pkg.sv
// Shared types and constants for the midpoint circle engine.
package circle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    STEP,
    DONE
  } state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COORD_W      = 10;
  localparam int CRIT_W       = 11;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [CRIT_W-1:0]  crit_t;

  // off_x may dip to -1 on the final step of a radius-0 circle, so widen it as signed.
  function automatic crit_t sext_off(input logic [8:0] v);
    return crit_t'({{2{v[8]}}, v});
  endfunction

  function automatic crit_t zext_off(input logic [8:0] v);
    return crit_t'({2'b00, v});
  endfunction

endpackage

// File: rtl/circle_plotter_if.sv
// Request/response and pixel-write bundle between a requester and circle_plotter.
interface circle_plotter_if;

  logic       start;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output start, colour, centre_x, centre_y, radius,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, colour, centre_x, centre_y, radius,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/circle_plotter_octant_point.sv
// Maps centre, offsets and octant index to one signed outline point plus a clip flag.
module octant_point
  import circle_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [7:0] cx,
  input  logic [6:0] cy,
  input  logic [8:0] ox,
  input  logic [8:0] oy,
  input  logic [2:0] oct,
  output coord_t     px,
  output coord_t     py,
  output logic       in_bounds
);

  coord_t scx, scy, sox, soy;

  always_comb begin
    scx = coord_t'({2'b00, cx});
    scy = coord_t'({3'b000, cy});
    sox = coord_t'({1'b0, ox});
    soy = coord_t'({1'b0, oy});
    px  = scx;
    py  = scy;
    case (oct)
      3'd0: begin px = scx + sox; py = scy + soy; end
      3'd1: begin px = scx + soy; py = scy + sox; end
      3'd2: begin px = scx - sox; py = scy + soy; end
      3'd3: begin px = scx - soy; py = scy + sox; end
      3'd4: begin px = scx - sox; py = scy - soy; end
      3'd5: begin px = scx - soy; py = scy - sox; end
      3'd6: begin px = scx + sox; py = scy - soy; end
      3'd7: begin px = scx + soy; py = scy - sox; end
      default: begin px = scx; py = scy; end
    endcase
    in_bounds = (px >= coord_t'(0)) && (px < coord_t'(SCREEN_W)) &&
                (py >= coord_t'(0)) && (py < coord_t'(SCREEN_H));
  end

endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle engine: one candidate outline pixel per clock, done when the outline is complete.
module circle_plotter
  import circle_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  circle_plotter_if.slave  bus
);

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [2:0] col_q, col_d;
  logic [7:0] r_q, r_d;
  logic [8:0] ox_q, ox_d;
  logic [8:0] oy_q, oy_d;
  crit_t      crit_q, crit_d;
  logic [2:0] oct_q, oct_d;

  logic [8:0] ox_new, oy_new;
  crit_t      ox_ext, oy_ext;
  logic       crit_le0;
  coord_t     px, py;
  logic       in_bounds;

  octant_point #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_octant_point (
    .cx        (cx_q),
    .cy        (cy_q),
    .ox        (ox_q),
    .oy        (oy_q),
    .oct       (oct_q),
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      col_q   <= '0;
      r_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      crit_q  <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      col_q   <= col_d;
      r_q     <= r_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      crit_q  <= crit_d;
      oct_q   <= oct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    r_d     = r_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    oct_d   = oct_q;

    crit_le0 = (crit_q <= crit_t'(0));
    oy_new   = oy_q + 9'd1;
    ox_new   = crit_le0 ? ox_q : ox_q - 9'd1;
    oy_ext   = zext_off(oy_new);
    ox_ext   = sext_off(ox_new);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cx_d    = bus.centre_x;
          cy_d    = bus.centre_y;
          col_d   = bus.colour;
          r_d     = bus.radius;
          state_d = INIT;
        end
      end
      INIT: begin
        ox_d    = {1'b0, r_q};
        oy_d    = '0;
        crit_d  = crit_t'(1) - crit_t'({3'b000, r_q});
        oct_d   = '0;
        state_d = PLOT;
      end
      PLOT: begin
        oct_d = oct_q + 3'd1;
        if (oct_q == 3'd7) begin
          state_d = STEP;
        end
      end
      STEP: begin
        oy_d = oy_new;
        ox_d = ox_new;
        // Decision variable update uses the already-advanced offsets.
        if (crit_le0) begin
          crit_d = crit_q + (oy_ext <<< 1) + crit_t'(1);
        end else begin
          crit_d = crit_q + ((oy_ext - ox_ext) <<< 1) + crit_t'(1);
        end
        oct_d   = '0;
        state_d = (oy_ext > ox_ext) ? DONE : PLOT;
      end
      DONE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.done       = (state_q == DONE);
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.vga_plot   = 1'b0;
    // Clipped points still occupy their cycle; only the strobe is suppressed.
    if (state_q == PLOT) begin
      bus.vga_x      = 8'(px);
      bus.vga_y      = 7'(py);
      bus.vga_colour = col_q;
      bus.vga_plot   = in_bounds;
    end
  end

endmodule
